phys_reg_free_list: RTL
=======================

# phys_reg_free_list

Physical-register free-list controller for the renamed RV32I pipeline. It hands out a new destination physical register (`dest_phys_new`) to the rename stage. It reclaims the previous mapping (`dest_phys_old`) when an instruction commits. On a flush it rolls the allocation pointer back to the committed state in one cycle. It owns the 6-bit physical register namespace: p0..p31 hold the reset architectural mapping, and p32..p63 start free.

## Interface
- `PHYS_REGS`, default 64: total physical registers.
- `ARCH_REGS`, default 32: architectural registers; free-list depth is `PHYS_REGS-ARCH_REGS` (32).
- `PREG_W`, default 6: physical register index width.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `alloc_req`, in, 1: rename needs a destination; upstream asserts it only for `regf_we` with `dest_arch != 0`.
- `alloc_gnt`, out, 1: allocation accepted this cycle.
- `alloc_preg`, out, PREG_W: register granted; valid when `alloc_gnt`.
- `commit_valid`, in, 1: an instruction retires this cycle.
- `commit_has_dest`, in, 1: the retiring instruction allocated a register.
- `commit_dest_phys_old`, in, PREG_W: previous mapping to reclaim.
- `flush`, in, 1: squash all uncommitted allocations.
- `free_count`, out, 6: speculative free entries, 0..32.
- `empty`, out, 1: `free_count == 0`.
- `err`, out, 1: sticky illegal-free flag.

## Operation
- **Storage:** 32-entry circular buffer `fl_mem` of PREG_W entries.
- **Pointers:** three 6-bit pointers (5-bit index plus wrap bit): `spec_head` (allocation), `commit_head` (committed allocation), `tail` (reclaim).
- **`free_count`:**
  - `free_count = tail - spec_head`, modulo 64, using the wrap bit.
  - Invariant: `tail - commit_head == 32` whenever `err == 0`.
- **Allocate:**
  - `alloc_gnt = alloc_req & !empty & !flush`.
  - `alloc_preg = fl_mem[spec_head[4:0]]`.
  - On grant, `spec_head` increments.
- **Reclaim:** a legal free is `commit_valid & commit_has_dest`, `commit_dest_phys_old != 0`, and `free_count != 32`. On a legal free:
  - write `fl_mem[tail[4:0]] <= commit_dest_phys_old`;
  - increment `tail`;
  - increment `commit_head`.
- **Illegal free:** either of the following ignores the whole commit event (no pointer moves, no write) and sets `err <= 1`:
  - `commit_dest_phys_old == 0`;
  - `free_count == 32`, i.e. overflow.
- **No-op commits:** `commit_valid` with `!commit_has_dest` has no effect.
- **Flush:**
  - `spec_head <= commit_head_next`, the `commit_head` value including any same-cycle legal commit.
  - No allocation is granted in the flush cycle.
  - After a flush, `free_count == 32`.
- **Simultaneous alloc and free:**
  - Both pointers move in the same cycle, so `free_count` is unchanged.
  - The freed register is not bypassed. If the list is empty, `alloc_gnt = 0` that cycle, and the freed register becomes available the next cycle.
- **Arithmetic:** all pointer increments wrap modulo 64. The index is bits [4:0]; bit 5 distinguishes full from empty.

## Timing
- **Reset values (asynchronous, while `rst_n = 0`):**
  - `spec_head = 0`, `commit_head = 0`, `tail = 6'b100000`;
  - `fl_mem[i] = 32+i`;
  - `err = 0`, so `free_count = 32`, `empty = 0`, `alloc_gnt = 0` (with `alloc_req = 0`), `alloc_preg = 32`.
- **Combinational outputs:** `alloc_gnt` and `alloc_preg` are combinational from registered state plus `alloc_req`/`flush`. Zero-cycle grant; the consumer latches `alloc_preg` on the same edge.
- **Registered effects:** pointer, memory and `err` updates are visible the cycle after the event. `free_count` and `empty` are registered-derived, so they lag by one edge.
- **Throughput:** one allocation and one reclaim per cycle maximum.
- **Reset mid-operation:** all in-flight allocations are discarded and the list returns to the reset image; `err` clears only on reset.
- **Flush with commit in the same cycle:** the commit is applied first, then `spec_head` snaps to the updated `commit_head`.

## Test plan
- **Reset image:** hold `rst_n = 0`, release, no requests.
  - Expect `free_count = 32`, `empty = 0`, `alloc_preg = 32`, `err = 0`.
- **Drain to empty:** assert `alloc_req` for 33 cycles.
  - Expect grants returning p32..p63 in order, then `alloc_gnt = 0` on cycle 33, with `empty = 1` and `free_count = 0`.
- **Reclaim after empty:** from empty, commit with `commit_has_dest = 1` and `commit_dest_phys_old = 5`, while `alloc_req = 1` in the same cycle.
  - Expect `alloc_gnt = 0` that cycle.
  - Next cycle: `alloc_gnt = 1` with `alloc_preg = 5`.
- **Flush rollback:** allocate p32..p41 (10), commit 3 freeing p1, p2, p3, then flush.
  - Expect `free_count = 32` next cycle.
  - Next allocation returns p35, followed by p36...
- **Flush with same-cycle commit:** after 4 allocations, assert commit (old = 7) and `flush` together.
  - Expect `commit_head = 1`, `spec_head = 1`, `free_count = 32`, and p7 stored at the old tail slot.
- **Illegal frees:**
  - Commit with `commit_dest_phys_old = 0` → `err = 1`, pointers unchanged.
  - Commit with old = 9 at reset (list full) → `err` stays 1, `free_count` stays 32.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Physical-register free list: speculative allocation, commit-time reclaim,
// single-cycle flush rollback to the committed allocation point.
module phys_reg_free_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int PREG_W = 6,
    localparam int DEPTH = PHYS_REGS - ARCH_REGS,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              commit_valid,
    input  logic              commit_has_dest,
    input  logic [PREG_W-1:0] commit_dest_phys_old,
    input  logic              flush,
    output logic [PTR_W-1:0]  free_count,
    output logic              empty,
    output logic              err
);

    logic [PREG_W-1:0] fl_mem [DEPTH];
    logic [PTR_W-1:0]  spec_head;
    logic [PTR_W-1:0]  commit_head;
    logic [PTR_W-1:0]  tail;

    logic              full;
    logic              free_evt;
    logic              legal_free;
    logic              illegal_free;
    logic [PTR_W-1:0]  commit_head_next;
    logic [PTR_W-1:0]  spec_head_next;

    // Wrap bit makes tail - spec_head span 0..DEPTH without ambiguity.
    assign free_count = tail - spec_head;
    assign empty      = (free_count == '0);
    assign full       = (free_count == PTR_W'(DEPTH));

    assign alloc_gnt  = alloc_req & ~empty & ~flush;
    assign alloc_preg = fl_mem[spec_head[IDX_W-1:0]];

    assign free_evt     = commit_valid & commit_has_dest;
    assign legal_free   = free_evt & (commit_dest_phys_old != '0) & ~full;
    assign illegal_free = free_evt & ((commit_dest_phys_old == '0) | full);

    assign commit_head_next = commit_head + PTR_W'(legal_free);

    always_comb begin
        spec_head_next = spec_head;
        if (flush) begin
            spec_head_next = commit_head_next;
        end else if (alloc_gnt) begin
            spec_head_next = spec_head + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= PTR_W'(DEPTH);
            err         <= 1'b0;
        end else begin
            spec_head   <= spec_head_next;
            commit_head <= commit_head_next;
            if (legal_free) begin
                tail <= tail + PTR_W'(1);
            end
            if (illegal_free) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_mem[i] <= PREG_W'(ARCH_REGS + i);
            end
        end else if (legal_free) begin
            fl_mem[tail[IDX_W-1:0]] <= commit_dest_phys_old;
        end
    end

endmodule
